// File: rtl/serial_pkg.sv
// Shared constants and state type for the 32-bit serial link (tx and rx sides).
package serial_pkg;

   localparam int DATA_W     = 32;
   localparam int LEAD_BITS  = 1;
   localparam int TRAIL_BITS = 1;
   localparam int FRAME_LEN  = LEAD_BITS + DATA_W + TRAIL_BITS;
   localparam int CNT_W      = 6;

   typedef enum logic {
      RX_IDLE,
      RX_RECV
   } rx_state_t;

endpackage

// File: rtl/serial_sipo.sv
// Serial-in / parallel-out shift register, MSB arrives first.
module serial_sipo #(
   parameter int DATA_W = 32
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic              sdi,
   output logic [DATA_W-1:0] q
);

   // Shift one bit in at the LSB end when enabled.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (shift_en) begin
         q <= {q[DATA_W-2:0], sdi};
      end
   end

endmodule

// File: rtl/serial_rx.sv
// Receive side of the serial link: frame counting, word reassembly,
// holding register with valid/ack handshake, length error and overrun flags.
module serial_rx #(
   parameter int DATA_W     = serial_pkg::DATA_W,
   parameter int LEAD_BITS  = serial_pkg::LEAD_BITS,
   parameter int TRAIL_BITS = serial_pkg::TRAIL_BITS
) (
   input  logic              sclk,
   input  logic              rst_n,
   input  logic              data_enable,
   input  logic              sdi,
   input  logic              rd_ack,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              busy,
   output logic              frame_err,
   output logic              overrun
);

   import serial_pkg::*;

   localparam int FRAME_LEN = LEAD_BITS + DATA_W + TRAIL_BITS;

   // Sample indices that carry payload: [SHIFT_LO, SHIFT_HI)
   localparam logic [CNT_W-1:0] SHIFT_LO  = CNT_W'(LEAD_BITS);
   localparam logic [CNT_W-1:0] SHIFT_HI  = CNT_W'(LEAD_BITS + DATA_W);
   localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   rx_state_t          state, state_nx;
   logic [CNT_W-1:0]   cnt, cnt_nx;
   logic               shift_en;
   logic               eval;
   logic               ack_eff;
   logic [DATA_W-1:0]  shreg;

   serial_sipo #(
      .DATA_W (DATA_W)
   ) u_sipo (
      .sclk     (sclk),
      .rst_n    (rst_n),
      .shift_en (shift_en),
      .sdi      (sdi),
      .q        (shreg)
   );

   // State and sample counter registers.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RX_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   // Next state, counter update, shift enable and frame-end detection.
   // cnt holds the number of samples seen so far, which is also the index
   // of the sample being taken on the current edge while in RX_RECV.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shift_en = 1'b0;
      eval     = 1'b0;
      case (state)
         RX_IDLE: begin
            if (data_enable) begin
               state_nx = RX_RECV;
               cnt_nx   = CNT_W'(1);
               shift_en = (LEAD_BITS == 0);
            end
         end
         RX_RECV: begin
            if (data_enable) begin
               cnt_nx   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
               shift_en = (cnt >= SHIFT_LO) && (cnt < SHIFT_HI);
            end else begin
               state_nx = RX_IDLE;
               cnt_nx   = '0;
               eval     = 1'b1;
            end
         end
         default: begin
            state_nx = RX_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // An ack only counts while a word is actually held.
   assign ack_eff = rd_ack && data_valid;

   // Holding register and flags; an ack on the evaluation edge is applied
   // first, so a good frame then loads instead of flagging overrun.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (ack_eff) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end
         if (eval) begin
            if (cnt == FRAME_CNT) begin
               if (!data_valid || ack_eff) begin
                  data_out   <= shreg;
                  data_valid <= 1'b1;
               end else begin
                  overrun <= 1'b1;
               end
            end else begin
               frame_err <= 1'b1;
            end
         end
      end
   end

   // The state register itself is the registered busy flag.
   assign busy = (state == RX_RECV);

endmodule

// File: doc/serial_rx.md
# serial_rx

Receive side of the 32-bit SPI-like serial link. Samples the serial data line while chip-select is high and reassembles one 32-bit word per frame, MSB first. Holds the completed word for the consumer logic (calculator core / display path) behind a valid/ack handshake, and flags malformed and overrun frames. Shares `sclk` with the transmitter, so every bit is captured synchronously on the same edge the transmitter uses.

## Interface
Parameters:
- `DATA_W`, 32: payload bits per frame.
- `LEAD_BITS`, 1: samples discarded after chip-select rises (transmitter lead-in cycle).
- `TRAIL_BITS`, 1: samples discarded before chip-select falls (transmitter hold cycle).

Ports:
- `sclk` in 1: serial clock, the only clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `data_enable` in 1: chip-select from the transmitter; high for the whole frame.
- `sdi` in 1: serial data in.
- `rd_ack` in 1: consumer pulse; clears `data_valid`.
- `data_out` out `DATA_W`: last good word.
- `data_valid` out 1: `data_out` holds an unconsumed word.
- `busy` out 1: a frame is being received.
- `frame_err` out 1: one-cycle pulse on a bad frame length.
- `overrun` out 1: sticky; a good frame arrived while `data_valid` was high.

## Operation
- Frame length `FRAME_LEN = LEAD_BITS + DATA_W + TRAIL_BITS`, which is 34 by default. A frame is the run of consecutive posedges that sample `data_enable` = 1.
- States:
  - IDLE: `data_enable` = 1 sampled → RECV. This first sample is counted as sample 0.
  - RECV: every edge with `data_enable` = 1 increments the 6-bit sample counter, saturating at 63. Samples with index `LEAD_BITS` through `LEAD_BITS+DATA_W-1` are shifted into the shift register, MSB first (`shreg <= {shreg[DATA_W-2:0], sdi}`). All other samples are ignored. The first edge with `data_enable` = 0 → IDLE and evaluates the frame.
- Evaluation, on the edge where `data_enable` is sampled low:
  - count == `FRAME_LEN` and `data_valid` = 0: `data_out <= shreg`, `data_valid <= 1`.
  - count == `FRAME_LEN` and `data_valid` = 1: the word is dropped, `data_out` is unchanged, `overrun <= 1`.
  - count != `FRAME_LEN` (short, long or saturated): `frame_err` pulses, and `data_out`, `data_valid` and `overrun` are unchanged.
- `rd_ack` while `data_valid` = 1: `data_valid <= 0` and `overrun <= 0`. `rd_ack` while `data_valid` = 0 is ignored.
- `rd_ack` on the same edge as a good-frame evaluation: the ack is applied first. The new word loads, `data_valid` stays 1, and `overrun` is cleared, not set.
- Back-to-back frames with zero idle samples are impossible by protocol. A single low sample between frames is sufficient to separate them.
- `sdi` is don't-care while `data_enable` = 0.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `busy` = 0, `frame_err` = 0, `overrun` = 0. The shift register, counter and state are cleared.
- Reset asserted mid-frame aborts the frame with no error pulse. After release, a frame already in progress starts counting late, so it yields `frame_err`. This is intended.
- `busy` is registered: 1 from the edge after the first high sample, through the evaluation edge, where it drops to 0.
- Latency: `data_valid` rises on the first `sclk` posedge that samples `data_enable` low. With the companion transmitter this is 36 edges after its `load_data` pulse is sampled.
- `frame_err` is high for exactly one cycle, registered on the evaluation edge.

## Structure
- Shared package `serial_pkg`:
  - constants `DATA_W`, `LEAD_BITS`, `TRAIL_BITS`, `FRAME_LEN`, `CNT_W` = 6;
  - state enum `rx_state_t {RX_IDLE, RX_RECV}`.
  - The transmitter adopts the same constants.
- One sub-module, `serial_sipo`: a `DATA_W`-bit serial-in/parallel-out shift register with a shift enable. The top level contains the FSM, counter, holding register and handshake.

## Test plan
- Good frame: transmitter-model frame of 0xDEADBEEF → `data_valid` = 1 and `data_out` = 0xDEADBEEF on the first edge after `data_enable` falls; `frame_err` = 0.
- Edge patterns: words 0x00000001 and 0x80000000 sent back-to-back with one idle sample, with `rd_ack` between them → each word received exactly, MSB/LSB order correct.
- Overrun: 0x12345678 followed by 0xCAFEF00D without `rd_ack` → `data_out` stays 0x12345678 and `overrun` = 1. Then `rd_ack` → `data_valid` = 0 and `overrun` = 0.
- Bad length: `data_enable` held 20 samples, then 40 samples → `frame_err` pulses one cycle each time, `data_valid` stays 0, `data_out` unchanged.
- Simultaneous events: `rd_ack` on the same edge as the evaluation of frame 0x0F0F0F0F, while `data_valid` = 1 → `data_out` = 0x0F0F0F0F, `data_valid` = 1, `overrun` = 0.
- Reset mid-frame: assert `rst_n` = 0 at sample 10 of a frame, release it at sample 15 → all outputs 0 during reset, then one `frame_err` at the frame end, and a following good frame of 0xA5A5A5A5 is received correctly.
